wvb_rd_arbiter: RTL

Round-robin arbiter that shares one `wvb_reader` (and its DPRAM) among N per-channel `waveform_buffer` instances. It grants the reader to one channel with a pending header and routes that channel's header/waveform FIFO data and read strobes. It holds the grant until the reader signals `wvb_rddone`, then moves on. It sits between the channel waveform buffers and the single readout path.

---
 rtl/wvb_rd_arbiter_pkg.sv | 18 +
 rtl/wvb_rd_arbiter_if.sv | 46 ++++
 rtl/wvb_rd_arbiter_rr_priority_pick.sv | 46 ++++
 rtl/wvb_rd_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/wvb_rd_arbiter_pkg.sv
// Shared constants and types for the waveform-buffer read arbiter.
//   N_CHAN     : number of waveform buffer channels
//   HDR_W      : header FIFO word width
//   WVB_W      : waveform FIFO word width
//   CHAN_IDX_W : width of a channel index
package wvb_rd_arb_pkg;

    localparam int unsigned N_CHAN     = 24;
    localparam int unsigned HDR_W      = 80;
    localparam int unsigned WVB_W      = 22;
    localparam int unsigned CHAN_IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wvb_rd_arbiter_if.sv
// Bus between N per-channel waveform buffers, the shared reader and the
// arbiter that routes between them.
//   master : arbiter side (drives channel strobes, reader-facing data, status)
//   slave  : environment side (channel FIFOs, reader, control)
interface wvb_rd_arbiter_if;
    import wvb_rd_arb_pkg::*;

    // control
    logic                        en;
    logic [N_CHAN-1:0]           chan_mask;
    // channel side
    logic [N_CHAN-1:0]           ch_hdr_empty;
    logic [N_CHAN*HDR_W-1:0]     ch_hdr_data;
    logic [N_CHAN*WVB_W-1:0]     ch_wvb_data;
    logic [N_CHAN-1:0]           ch_hdr_rdreq;
    logic [N_CHAN-1:0]           ch_wvb_rdreq;
    logic [N_CHAN-1:0]           ch_wvb_rddone;
    // reader side
    logic                        rdr_hdr_empty;
    logic [HDR_W-1:0]            rdr_hdr_data;
    logic [WVB_W-1:0]            rdr_wvb_data;
    logic                        rdr_hdr_rdreq;
    logic                        rdr_wvb_rdreq;
    logic                        rdr_rddone;
    // status
    logic                        busy;
    logic [CHAN_IDX_W-1:0]       grant_chan;
    logic [31:0]                 n_grants;

    modport master (
        input  en, chan_mask, ch_hdr_empty, ch_hdr_data, ch_wvb_data,
               rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_rddone,
        output ch_hdr_rdreq, ch_wvb_rdreq, ch_wvb_rddone,
               rdr_hdr_empty, rdr_hdr_data, rdr_wvb_data,
               busy, grant_chan, n_grants
    );

    modport slave (
        output en, chan_mask, ch_hdr_empty, ch_hdr_data, ch_wvb_data,
               rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_rddone,
        input  ch_hdr_rdreq, ch_wvb_rdreq, ch_wvb_rddone,
               rdr_hdr_empty, rdr_hdr_data, rdr_wvb_data,
               busy, grant_chan, n_grants
    );

endinterface

// File: rtl/wvb_rd_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set bit of req searching upward
// from last+1, wrapping modulo N_CHAN.
//   req   : request vector
//   last  : previously granted channel (lowest priority)
//   pick  : chosen channel (meaningful only when valid)
//   valid : any request present
module rr_priority_pick
    import wvb_rd_arb_pkg::*;
(
    input  logic [N_CHAN-1:0]     req,
    input  logic [CHAN_IDX_W-1:0] last,
    output logic [CHAN_IDX_W-1:0] pick,
    output logic                  valid
);

    localparam int unsigned SUM_W = CHAN_IDX_W + 1;

    logic [2*N_CHAN-1:0] dbl;
    logic [N_CHAN-1:0]   rot;
    logic [SUM_W-1:0]    start;
    logic [SUM_W-1:0]    offs;
    logic [SUM_W-1:0]    sum_raw;
    logic [SUM_W-1:0]    sum_mod;

    always_comb begin
        start = SUM_W'(last) + SUM_W'(1);
        // Rotating the doubled vector puts channel last+1 at bit 0.
        dbl   = {req, req} >> start;
        rot   = dbl[N_CHAN-1:0];
        valid = |req;

        // Downward scan: the lowest set bit is written last and wins.
        offs = '0;
        for (int unsigned i = N_CHAN; i > 0; i--) begin
            if (rot[i-1]) begin
                offs = SUM_W'(i - 1);
            end
        end

        // start <= N_CHAN and offs < N_CHAN, so one subtraction suffices.
        sum_raw = start + offs;
        sum_mod = (sum_raw >= SUM_W'(N_CHAN)) ? (sum_raw - SUM_W'(N_CHAN)) : sum_raw;
        pick    = sum_mod[CHAN_IDX_W-1:0];
    end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Round-robin arbiter sharing one waveform reader among N_CHAN channel
// waveform buffers. A grant is held until the reader pulses rdr_rddone.
//   clk : system clock
//   rst : synchronous, active-low reset
//   bus : arbiter side of wvb_rd_arbiter_if (channel FIFOs, reader, status)
module wvb_rd_arbiter
    import wvb_rd_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    wvb_rd_arbiter_if.master bus
);

    arb_state_t            state_q;
    logic [CHAN_IDX_W-1:0] grant_chan_q;
    logic [CHAN_IDX_W-1:0] last_q;
    logic [31:0]           n_grants_q;
    logic [31:0]           n_grants_d;
    logic                  busy_q;

    logic [N_CHAN-1:0]     req;
    logic [CHAN_IDX_W-1:0] pick;
    logic                  pick_valid;

    assign req        = bus.chan_mask & ~bus.ch_hdr_empty;
    assign n_grants_d = n_grants_q + 32'd1;

    rr_priority_pick u_pick (
        .req   (req),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_chan_q <= '0;
            last_q       <= CHAN_IDX_W'(N_CHAN - 1);
            n_grants_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en && pick_valid) begin
                        grant_chan_q <= pick;
                        last_q       <= pick;
                        n_grants_q   <= n_grants_d;
                        busy_q       <= 1'b1;
                        state_q      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (bus.rdr_rddone) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe routing is combinational so the reader sees show-ahead FIFO timing.
    always_comb begin
        bus.ch_hdr_rdreq  = '0;
        bus.ch_wvb_rdreq  = '0;
        bus.ch_wvb_rddone = '0;
        bus.rdr_hdr_empty = 1'b1;
        if (state_q == ST_GRANT) begin
            bus.rdr_hdr_empty               = bus.ch_hdr_empty[grant_chan_q];
            bus.ch_hdr_rdreq[grant_chan_q]  = bus.rdr_hdr_rdreq;
            bus.ch_wvb_rdreq[grant_chan_q]  = bus.rdr_wvb_rdreq;
            bus.ch_wvb_rddone[grant_chan_q] = bus.rdr_rddone;
        end
    end

    assign bus.rdr_hdr_data = bus.ch_hdr_data[int'(grant_chan_q)*HDR_W +: HDR_W];
    assign bus.rdr_wvb_data = bus.ch_wvb_data[int'(grant_chan_q)*WVB_W +: WVB_W];
    assign bus.busy         = busy_q;
    assign bus.grant_chan   = grant_chan_q;
    assign bus.n_grants     = n_grants_q;

endmodule
